mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  Memory/write-back stage: accepts one executed instruction per handshake, issues loads/stores
//  to the data cache, waits out misses, then drives the register-file write port (RegWrite, rd, in).
//  Outputs are registered on posedge clk, so they are stable when the register file writes on negedge.
// PARAMETERS
//  DATA_W  32  datapath / register width
//  ADDR_W  32  data-cache address width
//  REG_AW  5   register index width
//  CNT_W   16  width of the miss-stall counter
// PORTS
//  clk            in   1       clock, posedge
//  rst            in   1       asynchronous, active-high reset
//  in_valid       in   1       upstream instruction valid
//  in_ready       out  1       stage accepts; transfer = in_valid & in_ready at posedge
//  ex_result      in   DATA_W  ALU result / memory address
//  ex_store_data  in   DATA_W  store data
//  ex_rd          in   REG_AW  destination register
//  ex_reg_write   in   1       instruction writes rd
//  ex_mem_read    in   1       load
//  ex_mem_write   in   1       store
//  ex_size        in   2       00 byte, 01 half, 10 word (LOAD_EXT_EN only)
//  ex_sign        in   1       sign-extend sub-word load (LOAD_EXT_EN only)
//  dc_req         out  1       cache request, held until dc_ack
//  dc_we          out  1       1 store, 0 load
//  dc_addr        out  ADDR_W  cache address
//  dc_wdata       out  DATA_W  store data
//  dc_be          out  4       byte enables
//  dc_rdata       in   DATA_W  load data, valid when dc_ack
//  dc_ack         in   1       cache done; may be asserted in the first dc_req cycle (hit)
//  RegWrite       out  1       register-file write enable, one-cycle pulse
//  rd             out  REG_AW  register-file write index
//  in             out  DATA_W  register-file write data
//  stall          out  1       = ~in_ready, to hazard/fetch logic
//  miss_cnt       out  CNT_W   cycles spent in MEM with dc_ack low; saturates at all-ones
// BEHAVIOUR
//  Reset: FSM=IDLE; in_ready=1; dc_req, dc_we, RegWrite, rd, in, dc_addr, dc_wdata, miss_cnt = 0; dc_be=4'hF.
//  FSM IDLE: in_ready=1. On transfer without memory op: latch rd/ex_result; next cycle RegWrite=1 (1 cycle).
//   On transfer with ex_mem_read or ex_mem_write: latch address, data, ctrl; go MEM.
//  FSM MEM: in_ready=0, dc_req=1, dc_we=store. dc_ack low: miss_cnt += 1 (saturating).
//   dc_ack high: load -> capture dc_rdata into in; go IDLE; RegWrite pulses the cycle after the ack edge.
//  Latency: ALU op write-back 1 cycle after accept; load min 2 cycles (hit), +1 per miss-wait cycle.
//  Back-to-back ALU ops: one per cycle, RegWrite may stay high across consecutive cycles.
//  rd==0 -> RegWrite forced 0. Stores never write back (ex_reg_write ignored).
//  ex_mem_read & ex_mem_write both set -> treated as load.
//  in_valid while in_ready=0: ignored; upstream holds its inputs.
//  rst mid-MEM: dc_req drops immediately (async), pending op discarded, no write-back after release.
// CONFIGURATION
//  LOAD_EXT_EN defined:
//   Load lane from dc_addr[1:0], little-endian, zero/sign-extended per ex_sign.
//   Stores replicate byte/half across lanes; dc_be selects lanes.
//   Word access ignores addr[1:0].
//  LOAD_EXT_EN undefined:
//   Ports kept; ex_size/ex_sign ignored; all accesses word; dc_be=4'hF; in=dc_rdata.
// TESTING
//  T1 ALU: rd=5, result=0x00001234 -> next cycle RegWrite=1, rd=5, in=0x00001234 for 1 cycle; dc_req never 1.
//  T2 load hit: addr=0x40, dc_ack in first dc_req cycle, dc_rdata=0xDEADBEEF -> in_ready low 1 cycle,
//     RegWrite next cycle with in=0xDEADBEEF; miss_cnt stays 0.
//  T3 load miss: dc_ack after 3 low cycles -> miss_cnt=3, stall high 4 cycles, then correct write-back.
//  T4 store addr=0x80 data=0xCAFEF00D, ex_reg_write=1 -> dc_we=1, dc_wdata=0xCAFEF00D, RegWrite stays 0;
//     ALU op with rd=0 -> RegWrite stays 0.
//  T5 rst pulsed during a MEM wait -> dc_req 0 same cycle, miss_cnt=0, no RegWrite after release.
//  T6 LOAD_EXT_EN: signed byte load addr=0x43, dc_rdata=0x80FFFF7F -> in=0xFFFFFF80;
//     unsigned half at 0x42 -> 0x000080FF.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   Memory / write-back pipeline stage. Accepts one executed instruction per
//   in_valid/in_ready handshake. ALU results go straight to the register-file
//   write port on the next cycle. Loads and stores are issued to the data
//   cache and held until dc_ack. A load's data then goes to the write port on
//   the cycle after the ack edge. All write-port outputs come from flops
//   clocked on posedge clk, so they are stable for a negedge register file.
//
//   Ports
//     clk, rst          clock (posedge), asynchronous active-high reset
//     in_valid/in_ready upstream handshake (in_ready high only when idle)
//     ex_*              executed instruction: result/address, store data,
//                       rd, write/read/store flags, access size and sign
//     dc_*              data-cache request: req/we/addr/wdata/be out,
//                       rdata/ack in
//     RegWrite, rd, in  register-file write port (RegWrite is a pulse per
//                       write; it is never raised for rd == 0)
//     stall             inverse of in_ready
//     miss_cnt          saturating count of MEM cycles with dc_ack low
//
//   Build option
//     LOAD_EXT_EN  When defined, the stage supports byte and halfword
//                  accesses. Load lanes are chosen by address (little-endian)
//                  and zero- or sign-extended. Store data is replicated across
//                  lanes and dc_be selects the lanes. This path assumes
//                  DATA_W = 32. When undefined, every access is a word
//                  access, dc_be = 4'hF, and ex_size and ex_sign are ignored.
// -----------------------------------------------------------------------------
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_size,
    input  logic              ex_sign,
    output logic              dc_req,
    output logic              dc_we,
    output logic [ADDR_W-1:0] dc_addr,
    output logic [DATA_W-1:0] dc_wdata,
    output logic [3:0]        dc_be,
    input  logic [DATA_W-1:0] dc_rdata,
    input  logic              dc_ack,
    output logic              RegWrite,
    output logic [REG_AW-1:0] rd,
    output logic [DATA_W-1:0] in,
    output logic              stall,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic {S_IDLE, S_MEM} state_t;

    state_t            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [REG_AW-1:0] pend_rd_q, pend_rd_d;
    logic              pend_wr_q, pend_wr_d;
    logic              reg_write_q, reg_write_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [DATA_W-1:0] st_wdata;   // store data as it will appear on the bus
    logic [3:0]        st_be;      // lane enables for the incoming access
    logic [DATA_W-1:0] load_data;  // dc_rdata aligned/extended for write-back
    logic              mem_op;

    // A load that also has the store flag set is still a load.
    assign mem_op = ex_mem_read | ex_mem_write;

`ifdef LOAD_EXT_EN
    logic [1:0] size_q, size_d;
    logic       sign_q, sign_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store lane preparation from the incoming instruction.
    always_comb begin
        st_wdata = ex_store_data;
        st_be    = 4'hF;
        case (ex_size)
            2'b00: begin
                st_wdata = {(DATA_W/8){ex_store_data[7:0]}};
                st_be    = 4'b0001 << ex_result[1:0];
            end
            2'b01: begin
                st_wdata = {(DATA_W/16){ex_store_data[15:0]}};
                st_be    = ex_result[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Load lane extraction uses the latched address and size.
    always_comb begin
        case (addr_q[1:0])
            2'd1:    ld_byte = dc_rdata[15:8];
            2'd2:    ld_byte = dc_rdata[23:16];
            2'd3:    ld_byte = dc_rdata[31:24];
            default: ld_byte = dc_rdata[7:0];
        endcase
        ld_half = addr_q[1] ? dc_rdata[31:16] : dc_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{(DATA_W-8){sign_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{(DATA_W-16){sign_q & ld_half[15]}}, ld_half};
            default: load_data = dc_rdata;
        endcase
    end

    always_comb begin
        size_d = size_q;
        sign_d = sign_q;
        if (state_q == S_IDLE && in_valid && mem_op) begin
            size_d = ex_size;
            sign_d = ex_sign;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            size_q <= 2'b10;
            sign_q <= 1'b0;
        end else begin
            size_q <= size_d;
            sign_q <= sign_d;
        end
    end
`else
    assign st_wdata  = ex_store_data;
    assign st_be     = 4'hF;
    assign load_data = dc_rdata;

    // Size and sign only matter for sub-word accesses.
    logic unused_ext;
    assign unused_ext = &{1'b0, ex_size, ex_sign};
`endif

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        pend_rd_d   = pend_rd_q;
        pend_wr_d   = pend_wr_q;
        rd_d        = rd_q;
        wb_data_d   = wb_data_q;
        miss_cnt_d  = miss_cnt_q;
        reg_write_d = 1'b0;         // write-back is a pulse unless re-armed

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (mem_op) begin
                        state_d    = S_MEM;
                        is_store_d = ex_mem_write & ~ex_mem_read;
                        addr_d     = ADDR_W'(ex_result);
                        wdata_d    = st_wdata;
                        be_d       = st_be;
                        pend_rd_d  = ex_rd;
                        // Stores never write back, whatever ex_reg_write says.
                        pend_wr_d  = ex_reg_write & ~(ex_mem_write & ~ex_mem_read)
                                     & (ex_rd != '0);
                    end else begin
                        reg_write_d = ex_reg_write & (ex_rd != '0);
                        rd_d        = ex_rd;
                        wb_data_d   = ex_result;
                    end
                end
            end
            S_MEM: begin
                if (dc_ack) begin
                    state_d     = S_IDLE;
                    reg_write_d = pend_wr_q;
                    if (!is_store_q) begin
                        rd_d      = pend_rd_q;
                        wb_data_d = load_data;
                    end
                end else if (miss_cnt_q != '1) begin
                    miss_cnt_d = miss_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= 4'hF;
            pend_rd_q   <= '0;
            pend_wr_q   <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            wb_data_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Request lines decode straight from the state flop, so an asynchronous
    // reset drops dc_req in the same cycle.
    assign in_ready = (state_q == S_IDLE);
    assign stall    = ~in_ready;
    assign dc_req   = (state_q == S_MEM);
    assign dc_we    = (state_q == S_MEM) & is_store_q;
    assign dc_addr  = addr_q;
    assign dc_wdata = wdata_q;
    assign dc_be    = be_q;
    assign RegWrite = reg_write_q;
    assign rd       = rd_q;
    assign in       = wb_data_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_stage
//   Directed bench for mem_wb_stage. Each instruction issued by the bench is
//   turned into an expected timeline indexed by cycle number: busy cycles,
//   cache-request contents, miss cycles, the ack cycle and the write-back
//   cycle. A negedge compare process checks the DUT against that timeline on
//   every cycle. Hand-computed literals pin the scenario results.
// -----------------------------------------------------------------------------
module tb_mem_wb_stage;

`ifdef LOAD_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ex_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic [1:0]  ex_size;
    logic        ex_sign;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_be;
    logic [31:0] dc_rdata;
    logic        dc_ack;
    logic        reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_in;
    logic        stall;
    logic [15:0] miss_cnt;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .ex_result(ex_result), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_size(ex_size), .ex_sign(ex_sign),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_be(dc_be), .dc_rdata(dc_rdata), .dc_ack(dc_ack),
        .RegWrite(reg_write), .rd(wb_rd), .in(wb_in),
        .stall(stall), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Expected timeline, keyed by cycle number.
    bit          busy_m[int];
    bit          we_m[int];
    logic [31:0] addr_m[int];
    logic [31:0] wdata_m[int];
    logic [3:0]  be_m[int];
    bit          wb_m[int];
    logic [4:0]  wbrd_m[int];
    logic [31:0] wbdat_m[int];
    logic [31:0] ack_m[int];
    int          miss_q[$];
    int          free_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Value the register file must receive for a load.
    function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                             input bit sg, input logic [31:0] d);
        logic [31:0] sh;
        logic [31:0] v;
        v = d;
        if (sz == 2'b00) begin
            sh = d >> (8 * a[1:0]);
            v  = {24'h0, sh[7:0]};
            if (sg && sh[7]) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            sh = d >> (a[1] ? 16 : 0);
            v  = {16'h0, sh[15:0]};
            if (sg && sh[15]) v = v - 32'd65536;
        end
        return EXT ? v : d;
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [1:0] sz);
        logic [3:0] b;
        b = 4'hF;
        if (sz == 2'b00) b = 4'b0001 << a[1:0];
        else if (sz == 2'b01) b = a[1] ? 4'b1100 : 4'b0011;
        return EXT ? b : 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] sd, input logic [1:0] sz);
        logic [31:0] w;
        w = sd;
        if (sz == 2'b00) w = {24'h0, sd[7:0]} * 32'h01010101;
        else if (sz == 2'b01) w = {16'h0, sd[15:0]} * 32'h00010001;
        return EXT ? w : sd;
    endfunction

    function automatic int misses_before(input int k);
        int n;
        n = 0;
        foreach (miss_q[i]) if (miss_q[i] < k) n++;
        return n;
    endfunction

    // Cache model: ack with the scheduled data, junk otherwise.
    always @(posedge clk) begin
        #1;
        if (ack_m.exists(cyc)) begin
            dc_ack   = 1'b1;
            dc_rdata = ack_m[cyc];
        end else begin
            dc_ack   = 1'b0;
            dc_rdata = 32'h5A5A_A5A5;
        end
    end

    // Per-cycle compare against the expected timeline.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'd0, stall}, {31'd0, busy_m.exists(cyc)});
            chk("in_ready", {31'd0, in_ready}, {31'd0, !busy_m.exists(cyc)});
            chk("dc_req", {31'd0, dc_req}, {31'd0, busy_m.exists(cyc)});
            if (busy_m.exists(cyc)) begin
                chk("dc_we", {31'd0, dc_we}, {31'd0, we_m[cyc]});
                chk("dc_addr", dc_addr, addr_m[cyc]);
                chk("dc_be", {28'd0, dc_be}, {28'd0, be_m[cyc]});
                if (we_m[cyc]) chk("dc_wdata", dc_wdata, wdata_m[cyc]);
            end else begin
                chk("dc_we_idle", {31'd0, dc_we}, 32'd0);
            end
            chk("RegWrite", {31'd0, reg_write}, {31'd0, wb_m.exists(cyc)});
            if (wb_m.exists(cyc)) begin
                chk("rd", {27'd0, wb_rd}, {27'd0, wbrd_m[cyc]});
                chk("in", wb_in, wbdat_m[cyc]);
            end
            chk("miss_cnt", {16'd0, miss_cnt}, misses_before(cyc));
        end
    end

    // Advance to posedge+1 of cycle k.
    task automatic to_cyc(input int k);
        for (int g = 0; g < 500 && cyc < k; g++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one instruction, record its expected timeline, hold it until
    // accepted; returns the cycle in which it was accepted.
    task automatic issue(input bit mr, input bit mw, input bit regw, input logic [4:0] r,
                         input logic [31:0] res, input logic [31:0] sd,
                         input logic [1:0] sz, input bit sg, input int m,
                         input logic [31:0] rdata, output int acc);
        int a;
        bit st;
        ex_result = res; ex_store_data = sd; ex_rd = r; ex_reg_write = regw;
        ex_mem_read = mr; ex_mem_write = mw; ex_size = sz; ex_sign = sg;
        in_valid = 1'b1;
        a = (cyc > free_cyc) ? cyc : free_cyc;
        acc = a;
        if (!(mr || mw)) begin
            if (regw && r != 5'd0) begin
                wb_m[a+1] = 1'b1; wbrd_m[a+1] = r; wbdat_m[a+1] = res;
            end
            free_cyc = a + 1;
        end else begin
            st = mw && !mr;
            for (int j = 0; j <= m; j++) begin
                busy_m[a+1+j]  = 1'b1;
                we_m[a+1+j]    = st;
                addr_m[a+1+j]  = res;
                wdata_m[a+1+j] = exp_wdata(sd, sz);
                be_m[a+1+j]    = exp_be(res, sz);
            end
            for (int j = 0; j < m; j++) miss_q.push_back(a + 1 + j);
            ack_m[a+1+m] = rdata;
            if (!st && regw && r != 5'd0) begin
                wb_m[a+2+m] = 1'b1; wbrd_m[a+2+m] = r;
                wbdat_m[a+2+m] = exp_load(res, sz, sg, rdata);
            end
            free_cyc = a + 2 + m;
        end
        to_cyc(a + 1);
        if (cyc < a + 1) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout cyc=%0d got=not_accepted want=accept_by_%0d", cyc, a + 1);
        end
        // Junk on the bus while not valid must be ignored.
        in_valid = 1'b0;
        ex_rd = 5'd31; ex_result = 32'hBAAD_F00D; ex_reg_write = 1'b1;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    endtask

    int a;

    initial begin
        rst = 1'b1; in_valid = 1'b0;
        ex_result = '0; ex_store_data = '0; ex_rd = '0; ex_reg_write = 1'b0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_size = 2'b10; ex_sign = 1'b0;
        dc_ack = 1'b0; dc_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_RegWrite", {31'd0, reg_write}, 32'd0);
        chk("rst_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_in", wb_in, 32'd0);
        chk("rst_dc_req", {31'd0, dc_req}, 32'd0);
        chk("rst_dc_we", {31'd0, dc_we}, 32'd0);
        chk("rst_dc_addr", dc_addr, 32'd0);
        chk("rst_dc_wdata", dc_wdata, 32'd0);
        chk("rst_dc_be", {28'd0, dc_be}, 32'hF);
        chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
        rst = 1'b0;
        free_cyc = cyc;
        chk_en = 1'b1;

        // T1: ALU write-back one cycle after accept.
        issue(0, 0, 1, 5'd5, 32'h0000_1234, 32'h0, 2'b10, 0, 0, 32'h0, a);
        @(negedge clk);
        chk("T1_RegWrite", {31'd0, reg_write}, 32'd1);
        chk("T1_rd", {27'd0, wb_rd}, 32'd5);
        chk("T1_in", wb_in, 32'h0000_1234);
        to_cyc(a + 2);
        @(negedge clk);
        chk("T1_pulse_end", {31'd0, reg_write}, 32'd0);

        // T2: load hit.
        to_cyc(cyc + 1);
        issue(1, 0, 1, 5'd7, 32'h0000_0040, 32'h0, 2'b10, 0, 0, 32'hDEAD_BEEF, a);
        @(negedge clk);
        chk("T2_stall", {31'd0, stall}, 32'd1);
        to_cyc(a + 2);
        @(negedge clk);
        chk("T2_RegWrite", {31'd0, reg_write}, 32'd1);
        chk("T2_in", wb_in, 32'hDEAD_BEEF);
        chk("T2_miss_cnt", {16'd0, miss_cnt}, 32'd0);

        // T3: load with three miss cycles.
        to_cyc(cyc + 1);
        issue(1, 0, 1, 5'd9, 32'h0000_0044, 32'h0, 2'b10, 0, 3, 32'h1234_5678, a);
        to_cyc(a + 5);
        @(negedge clk);
        chk("T3_in", wb_in, 32'h1234_5678);
        chk("T3_rd", {27'd0, wb_rd}, 32'd9);
        chk("T3_miss_cnt", {16'd0, miss_cnt}, 32'd3);

        // T4: store with ex_reg_write set, then an ALU op to rd=0 held during the stall.
        to_cyc(cyc + 1);
        issue(0, 1, 1, 5'd8, 32'h0000_0080, 32'hCAFE_F00D, 2'b10, 0, 1, 32'h0, a);
        @(negedge clk);
        chk("T4_dc_we", {31'd0, dc_we}, 32'd1);
        chk("T4_dc_wdata", dc_wdata, 32'hCAFE_F00D);
        chk("T4_dc_addr", dc_addr, 32'h0000_0080);
        to_cyc(cyc + 1);
        issue(0, 0, 1, 5'd0, 32'h0000_5555, 32'h0, 2'b10, 0, 0, 32'h0, a);
        @(negedge clk);
        chk("T4_rd0_RegWrite", {31'd0, reg_write}, 32'd0);

        // Back-to-back ALU ops, a read+write (treated as load) followed
        // immediately by an ALU op that must wait out the miss.
        to_cyc(cyc + 1);
        issue(0, 0, 1, 5'd3, 32'h0000_0003, 32'h0, 2'b10, 0, 0, 32'h0, a);
        issue(0, 0, 1, 5'd4, 32'h0000_0004, 32'h0, 2'b10, 0, 0, 32'h0, a);
        issue(0, 0, 0, 5'd6, 32'h0000_0006, 32'h0, 2'b10, 0, 0, 32'h0, a);
        issue(1, 1, 1, 5'd11, 32'h0000_0048, 32'h1111_1111, 2'b10, 0, 2, 32'hA5A5_0F0F, a);
        issue(0, 0, 1, 5'd12, 32'h0000_00CC, 32'h0, 2'b10, 0, 0, 32'h0, a);
        @(negedge clk);
        chk("B2B_in", wb_in, 32'h0000_00CC);

        // T6: sub-word accesses.
        to_cyc(cyc + 1);
        issue(1, 0, 1, 5'd10, 32'h0000_0043, 32'h0, 2'b00, 1, 0, 32'h80FF_FF7F, a);
        to_cyc(a + 2);
        @(negedge clk);
        chk("T6_sbyte", wb_in, EXT ? 32'hFFFF_FF80 : 32'h80FF_FF7F);
        to_cyc(cyc + 1);
        issue(1, 0, 1, 5'd13, 32'h0000_0042, 32'h0, 2'b01, 0, 1, 32'h80FF_FF7F, a);
        to_cyc(a + 3);
        @(negedge clk);
        chk("T6_uhalf", wb_in, EXT ? 32'h0000_80FF : 32'h80FF_FF7F);
        to_cyc(cyc + 1);
        issue(0, 1, 0, 5'd0, 32'h0000_0041, 32'h0000_00AB, 2'b00, 0, 0, 32'h0, a);
        @(negedge clk);
        chk("T6_sb_wdata", dc_wdata, EXT ? 32'hABAB_ABAB : 32'h0000_00AB);
        chk("T6_sb_be", {28'd0, dc_be}, EXT ? 32'h2 : 32'hF);

        // T5: reset during a miss wait.
        to_cyc(cyc + 1);
        issue(1, 0, 1, 5'd14, 32'h0000_0050, 32'h0, 2'b10, 0, 40, 32'h7777_7777, a);
        to_cyc(a + 3);
        chk_en = 1'b0;
        chk("T5_req_before", {31'd0, dc_req}, 32'd1);
        chk("T5_miss_before", {16'd0, miss_cnt}, misses_before(cyc));
        #2 rst = 1'b1;
        #1;
        chk("T5_req_async", {31'd0, dc_req}, 32'd0);
        chk("T5_miss_async", {16'd0, miss_cnt}, 32'd0);
        chk("T5_ready_async", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        busy_m.delete(); we_m.delete(); addr_m.delete(); wdata_m.delete(); be_m.delete();
        wb_m.delete(); wbrd_m.delete(); wbdat_m.delete(); ack_m.delete(); miss_q.delete();
        free_cyc = cyc;
        chk_en = 1'b1;
        to_cyc(cyc + 45);
        @(negedge clk);
        chk("T5_no_wb", {31'd0, reg_write}, 32'd0);
        chk("T5_miss_after", {16'd0, miss_cnt}, 32'd0);
        to_cyc(cyc + 1);
        issue(0, 0, 1, 5'd2, 32'h0000_0099, 32'h0, 2'b10, 0, 0, 32'h0, a);
        @(negedge clk);
        chk("T5_alu_after", wb_in, 32'h0000_0099);
        to_cyc(cyc + 2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
